ascon_perm_ctrl: RTL
====================

# ascon_perm_ctrl

Sequencer wrapping the Ascon round datapath `asconp`. It accepts a 320-bit state over a valid/ready handshake and runs the Ascon-p permutation for 12, 8 or 6 rounds, applying `UROL` rounds per clock. It drives the round-constant index and returns the permuted state over a second handshake. It sits between the AEAD/hash mode FSM and the round datapath, and owns the only state register of the permutation.

## Interface
- `UROL`, default 1: rounds per clock; legal values 1 and 2. Other values are a compile-time error.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  start request; state and round count are valid
- `in_ready`  out  1  controller can accept a request
- `rounds_sel`  in  2  00 = 12 rounds, 01 = 8 rounds, 10 = 6 rounds, 11 = 12 rounds (reserved)
- `x0_i`..`x4_i`  in  64 each  input state words
- `out_valid`  out  1  permuted state available
- `out_ready`  in  1  consumer takes the result
- `x0_o`..`x4_o`  out  64 each  state register contents
- `busy`  out  1  high in RUN
- `abort`  in  1  only present with `ASCON_PERM_ABORT_EN`

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Round index `rnd`, 4 bits: the constant index of the first round applied this cycle. It ranges 0..11 and is driven to `asconp` as `round_cnt`.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`: load the state register from `x*_i`, set `rnd` = 12 − N, go to RUN.
  - N is 12, 8 or 6, per `rounds_sel`.
- RUN:
  - Each cycle, state ← `asconp` output and `rnd` ← `rnd` + `UROL`.
  - When `rnd` + `UROL` = 12, this cycle is the last round step; go to DONE.
- DONE:
  - `out_valid` = 1 and `x*_o` are stable.
  - On `out_ready`, go to IDLE.
  - No new request is accepted in the same cycle; `in_ready` stays 0 until IDLE.
- `x*_o` always reflect the state register, including in IDLE and RUN. They are only meaningful while `out_valid` = 1.
- `in_ready`, `out_valid` and `busy` are decoded from the FSM state only. They are registered, with no combinational path from input to output.
- `rnd` never exceeds 11 when it is applied. `rnd` = 12 is never presented to `asconp`.

## Timing
- Reset values: state register 0, `rnd` 0, FSM IDLE.
  - Outputs after reset: `in_ready` 1, `out_valid` 0, `busy` 0, `x*_o` 0.
- Latency is N/`UROL` RUN cycles. `out_valid` rises on the cycle after the last RUN cycle.
  - Accept edge at T gives first `out_valid` at T + N/`UROL` + 1.
  - Throughput: one permutation per N/`UROL` + 2 cycles when `out_ready` is held at 1.
- `out_valid` must stay high and `x*_o` must hold until `out_ready` is sampled high.
- `in_valid` and data may change freely while `in_ready` = 0. They are ignored.
- Reset asserted mid-RUN or mid-DONE returns to IDLE immediately, with all registers at their reset values.

## Configuration
- `ASCON_PERM_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort` = 1 in RUN or DONE: next state is IDLE, `rnd` ← 0, state register is kept. No `out_valid` pulse is produced for the aborted request.
  - `abort` in IDLE is ignored, and a request is not accepted that cycle.
  - `abort` has priority over `out_ready`.
- Not defined: no `abort` port exists and every accepted request completes.

## Structure
- Shared package `ascon_pkg` holds:
  - the FSM state enum `perm_state_t`;
  - the `rounds_sel` encodings as localparams;
  - the round-count-to-start-index constants (12→0, 8→4, 6→6);
  - the round-constant table `RC[0:11]` = F0, E1, D2, C3, B4, A5, 96, 87, 78, 69, 5A, 4B (hex).
- One sub-module: `asconp` (purely combinational round function, `UROL` rounds starting at `round_cnt`), instantiated once. The controller holds the only state register.

## Test plan
- Reset:
  - Stimulus: assert `rst` mid-RUN.
  - Response: the next cycle shows `in_ready` 1, `out_valid` 0, `busy` 0, `x*_o` 0.
- p12, `UROL` = 1:
  - Stimulus: accept a random state with `rounds_sel` 00 at T.
  - Response: `round_cnt` steps 0..11 over 12 cycles, `out_valid` first at T + 13, and `x*_o` match the golden model.
- p6, `UROL` = 2:
  - Stimulus: accept with `rounds_sel` 10.
  - Response: `round_cnt` = 6, 8, 10; `out_valid` at T + 4; result matches the golden model.
- Output backpressure:
  - Stimulus: hold `out_ready` 0 for 5 cycles after `out_valid`.
  - Response: `x*_o` are stable and `in_ready` stays 0. `in_ready` returns to 1 one cycle after `out_ready`.
- Reserved select and ignored request:
  - Stimulus: `rounds_sel` 11; `in_valid` pulsed again during RUN.
  - Response: 12 rounds are executed and the second request is ignored.
- Abort (`ASCON_PERM_ABORT_EN`):
  - Stimulus: `abort` on the 3rd RUN cycle.
  - Response: IDLE next cycle, no `out_valid`, and the next request completes correctly.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: FSM state enum, round-select encodings,
// start-index constants, round-constant table and the round function.
package ascon_pkg;

  localparam int unsigned XW     = 64;  // state word width
  localparam int unsigned RW     = 4;   // round index width
  localparam int unsigned NR_MAX = 12;  // rounds of the full permutation

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perm_state_t;

  // rounds_sel encodings
  localparam logic [1:0] SEL_P12 = 2'b00;
  localparam logic [1:0] SEL_P8  = 2'b01;
  localparam logic [1:0] SEL_P6  = 2'b10;
  localparam logic [1:0] SEL_RSV = 2'b11;

  // first constant index for each round count
  localparam logic [RW-1:0] START_P12 = 4'd0;
  localparam logic [RW-1:0] START_P8  = 4'd4;
  localparam logic [RW-1:0] START_P6  = 4'd6;

  localparam logic [7:0] RC [0:11] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [XW-1:0] x2;
    logic [XW-1:0] x3;
    logic [XW-1:0] x4;
  } ascon_state_t;

  // Reserved select falls back to the full 12-round permutation.
  function automatic logic [RW-1:0] start_idx(input logic [1:0] sel);
    case (sel)
      SEL_P12: return START_P12;
      SEL_P8:  return START_P8;
      SEL_P6:  return START_P6;
      SEL_RSV: return START_P12;
      default: return START_P12;
    endcase
  endfunction

  function automatic logic [7:0] rc_of(input logic [RW-1:0] idx);
    if (idx < RW'(NR_MAX)) return RC[idx];
    return 8'h00;
  endfunction

  function automatic logic [XW-1:0] ror(input logic [XW-1:0] v, input int unsigned n);
    return (v >> n) | (v << (XW - n));
  endfunction

  // One Ascon-p round: constant addition, bitsliced S-box, linear diffusion.
  function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [RW-1:0] idx);
    logic [XW-1:0] x0, x1, x2, x3, x4;
    logic [XW-1:0] t0, t1, t2, t3, t4;
    ascon_state_t  r;
    x0 = s.x0;
    x1 = s.x1;
    x2 = s.x2 ^ XW'(rc_of(idx));
    x3 = s.x3;
    x4 = s.x4;
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    r.x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    r.x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    r.x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    r.x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    r.x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return r;
  endfunction

endpackage

// File: rtl/ascon_perm_ctrl_if.sv
// Request/response bundle of the Ascon permutation controller.
// The abort signal exists only when ASCON_PERM_ABORT_EN is defined.
interface ascon_perm_ctrl_if;

  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                rounds_sel;
  logic [ascon_pkg::XW-1:0]  x0_i;
  logic [ascon_pkg::XW-1:0]  x1_i;
  logic [ascon_pkg::XW-1:0]  x2_i;
  logic [ascon_pkg::XW-1:0]  x3_i;
  logic [ascon_pkg::XW-1:0]  x4_i;
  logic                      out_valid;
  logic                      out_ready;
  logic [ascon_pkg::XW-1:0]  x0_o;
  logic [ascon_pkg::XW-1:0]  x1_o;
  logic [ascon_pkg::XW-1:0]  x2_o;
  logic [ascon_pkg::XW-1:0]  x3_o;
  logic [ascon_pkg::XW-1:0]  x4_o;
  logic                      busy;
`ifdef ASCON_PERM_ABORT_EN
  logic                      abort;
`endif

  // Requester side (mode FSM)
  modport master (
`ifdef ASCON_PERM_ABORT_EN
    output abort,
`endif
    output in_valid, rounds_sel, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready,
    input  in_ready, out_valid, busy, x0_o, x1_o, x2_o, x3_o, x4_o
  );

  // Controller side
  modport slave (
`ifdef ASCON_PERM_ABORT_EN
    input  abort,
`endif
    input  in_valid, rounds_sel, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready,
    output in_ready, out_valid, busy, x0_o, x1_o, x2_o, x3_o, x4_o
  );

endinterface

// File: rtl/asconp.sv
// Combinational Ascon round datapath: UROL rounds starting at round_cnt.
module asconp
  import ascon_pkg::*;
#(
  parameter int unsigned UROL = 1
) (
  input  logic [RW-1:0] round_cnt,
  input  ascon_state_t  state_i,
  output ascon_state_t  state_o
);

  // Chain UROL rounds with consecutive constant indices
  always_comb begin
    state_o = state_i;
    for (int unsigned r = 0; r < UROL; r++) begin
      state_o = ascon_round(state_o, round_cnt + RW'(r));
    end
  end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Ascon-p sequencer: accepts a 320-bit state, runs 12/8/6 rounds at UROL
// rounds per clock, and returns the result over a valid/ready handshake.
// Optional feature: ASCON_PERM_ABORT_EN adds an abort input.
module ascon_perm_ctrl
  import ascon_pkg::*;
#(
  parameter int unsigned UROL = 1
) (
  input  logic             clk,
  input  logic             rst,
  ascon_perm_ctrl_if.slave bus
);

  if (UROL != 1 && UROL != 2) begin : g_urol_check
    $error("ascon_perm_ctrl: UROL must be 1 or 2");
  end

  perm_state_t   state_q, state_d;
  logic [RW-1:0] rnd_q, rnd_d, rnd_step;
  ascon_state_t  st_q, st_d, perm_s;
  logic          last_step;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  asconp #(.UROL(UROL)) u_asconp (
    .round_cnt (rnd_q),
    .state_i   (st_q),
    .state_o   (perm_s)
  );

  assign rnd_step  = rnd_q + RW'(UROL);
  assign last_step = (rnd_step == RW'(NR_MAX));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus round index / state register update
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_RUN;
          rnd_d   = start_idx(bus.rounds_sel);
          st_d    = '{x0: bus.x0_i, x1: bus.x1_i, x2: bus.x2_i,
                      x3: bus.x3_i, x4: bus.x4_i};
        end
      end
      ST_RUN: begin
        st_d = perm_s;
        // Park the index at 0 so the datapath never sees index 12
        if (last_step) begin
          state_d = ST_DONE;
          rnd_d   = '0;
        end else begin
          rnd_d = rnd_step;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        rnd_d   = '0;
      end
    endcase
`ifdef ASCON_PERM_ABORT_EN
    // Abort wins over everything, keeps the state words, blocks acceptance
    if (bus.abort) begin
      state_d = ST_IDLE;
      rnd_d   = '0;
      st_d    = st_q;
    end
`endif
  end

  // Handshake flags decoded from the next FSM state
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_q <= '0;
      st_q  <= '0;
    end else begin
      rnd_q <= rnd_d;
      st_q  <= st_d;
    end
  end

  // Registered handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.x0_o      = st_q.x0;
  assign bus.x1_o      = st_q.x1;
  assign bus.x2_o      = st_q.x2;
  assign bus.x3_o      = st_q.x3;
  assign bus.x4_o      = st_q.x4;

endmodule
